seq_mult: RTL

//  Sequential shift-add unsigned multiplier; the upstream producer for a loadable

---
 rtl/seq_mult.sv | 116 +++++++++++
 1 files changed

// File: rtl/seq_mult.sv
// Sequential shift-add unsigned multiplier: one partial product per clock,
// then a one-cycle done pulse that serves as the downstream register's load enable.
module seq_mult #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     r_state;
    logic           r_busy;
    logic           r_done;
    logic [2*N-1:0] r_p;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mq;
    logic [CW-1:0]  r_count;

    logic [2*N-1:0] w_addend;
    logic [2*N-1:0] w_acc_sum;
    logic           w_last;

    // Partial-product add for the current iteration and last-iteration detect
    always_comb begin
        w_addend  = {(2*N){1'b0}};
        w_acc_sum = r_acc;
        w_last    = 1'b0;
        if (r_mq[0]) begin
            w_addend = r_mcand;
        end else begin
            w_addend = {(2*N){1'b0}};
        end
        w_acc_sum = r_acc + w_addend;
        if (r_count == CW'(N - 1)) begin
            w_last = 1'b1;
        end else begin
            w_last = 1'b0;
        end
    end

    // Control FSM and datapath registers; busy/done are registered alongside the state
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= {(2*N){1'b0}};
            r_acc   <= {(2*N){1'b0}};
            r_mcand <= {(2*N){1'b0}};
            r_mq    <= {N{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= {{N{1'b0}}, a};
                        r_mq    <= b;
                        r_acc   <= {(2*N){1'b0}};
                        r_count <= {CW{1'b0}};
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_sum;
                    r_mcand <= r_mcand << 1;
                    r_mq    <= r_mq >> 1;
                    r_count <= r_count + CW'(1);
                    // Always N iterations, no early exit on zero operands
                    if (w_last) begin
                        r_p     <= w_acc_sum;
                        r_state <= S_DONE;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

endmodule
